// File: rtl/rca_accumulator_pkg.sv
// Shared types and default sizes for the ripple-carry accumulator.
package rca_accumulator_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage : rca_accumulator_pkg

// File: rtl/rca_adder.sv
// WIDTH-bit ripple-carry adder: a chain of full-adder cells, LSB first.
module rca_adder #(
    parameter int unsigned WIDTH = rca_accumulator_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic p;
        assign p          = a[i] ^ b[i];
        assign sum[i]     = p ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & p);
    end

    assign cout = carry[WIDTH];

endmodule : rca_adder

// File: rtl/rca_accumulator.sv
// Multi-cycle reduction stage: folds a len-beat operand stream into one sum
// through a single ripple-carry adder, with a sticky carry-out flag.
module rca_accumulator
    import rca_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and datapath updates; handshake flags follow the next state
    // so they are registered yet line up with the state they describe.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule : rca_accumulator

// File: tb/tb_rca_accumulator.sv
// Directed and randomized checks of rca_accumulator against an arithmetic model.
module tb_rca_accumulator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    rca_accumulator #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden result from plain integer arithmetic over the beat list.
    task automatic model(input logic [WIDTH-1:0] beats[$], output logic [WIDTH-1:0] sum,
                         output logic ovf);
        longint unsigned s = 0;
        ovf = 1'b0;
        foreach (beats[i]) begin
            s = s + longint'(beats[i]);
            if (s >= 64'h1_0000_0000) begin
                ovf = 1'b1;
                s   = s - 64'h1_0000_0000;
            end
        end
        sum = WIDTH'(s);
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic start_run(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            chk("stall_no_result", 64'(out_valid), 64'(0));
        end
        chk("in_ready_accum", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic finish_run(input logic [WIDTH-1:0] exp_sum, input logic exp_ovf,
                              input int hold, input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
        chk({tag, "_in_ready_done"}, 64'(in_ready), 64'(0));
        out_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_hold_sum"}, 64'(out_sum), 64'(exp_sum));
            chk({tag, "_hold_ovf"}, 64'(out_ovf), 64'(exp_ovf));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] m_sum;
        logic             m_ovf;
        int               n;
        int               seen;

        // Reset with start and in_valid asserted.
        rst_n = 1'b0; start = 1'b1; len = 8'd3; in_valid = 1'b1;
        in_data = 32'd99; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'(0));

        // Basic run, immediate out_ready gives a 1-cycle result.
        start_run(3);
        chk("basic_busy", 64'(busy), 64'(1));
        feed(32'd10, 0);
        feed(32'd20, 0);
        feed(32'd30, 0);
        finish_run(32'd60, 1'b0, 0, "basic");

        // Zero-length run.
        start_run(0);
        chk("zero_in_ready", 64'(in_ready), 64'(0));
        finish_run(32'd0, 1'b0, 0, "zero");

        // Overflow wraps and sets ovf; next run clears it.
        start_run(2);
        feed(32'hFFFF_FFFF, 0);
        feed(32'h0000_0002, 0);
        finish_run(32'd1, 1'b1, 0, "wrap");
        start_run(1);
        feed(32'd5, 0);
        finish_run(32'd5, 1'b0, 0, "after_wrap");

        // Input gaps and output backpressure.
        start_run(2);
        feed(32'd1234, 3);
        feed(32'd4321, 3);
        finish_run(32'd5555, 1'b0, 4, "stall");

        // Start during ACCUM and during the DONE handshake is ignored.
        start_run(3);
        feed(32'd100, 0);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        feed(32'd200, 0);
        chk("busy_restart_no_result", 64'(out_valid), 64'(0));
        feed(32'd300, 0);
        chk("busy_restart_valid", 64'(out_valid), 64'(1));
        chk("busy_restart_sum", 64'(out_sum), 64'(600));
        start = 1'b1; len = 8'd0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("handshake_start_ignored_busy", 64'(busy), 64'(0));
        chk("handshake_start_ignored_valid", 64'(out_valid), 64'(0));

        // Reset mid-run discards the partial sum.
        start_run(4);
        feed(32'd11, 0);
        feed(32'd22, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        seen = 0;
        in_valid = 1'b1; in_data = 32'd77;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        chk("midrst_no_result", 64'(seen), 64'(0));
        start_run(1);
        feed(32'd7, 0);
        finish_run(32'd7, 1'b0, 0, "after_midrst");

        // Randomized runs against the model.
        for (int r = 0; r < 25; r++) begin
            q = {};
            n = int'($urandom_range(0, 9));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) q.push_back(32'hF000_0000 | WIDTH'($urandom));
                else q.push_back(WIDTH'($urandom));
            end
            model(q, m_sum, m_ovf);
            start_run(n);
            foreach (q[i]) feed(q[i], int'($urandom_range(0, 2)));
            if (n == 0) chk("rand_zero_in_ready", 64'(in_ready), 64'(0));
            finish_run(m_sum, m_ovf, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
        end

        // Bounded wait: a fresh len=1 run must produce a result within 20 cycles.
        start_run(1);
        in_valid = 1'b1; in_data = 32'd42;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("timeout_result", 64'(seen), 64'(1));
        chk("timeout_sum", 64'(out_sum), 64'(42));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rca_accumulator
